// File: rtl/noc_pkg.sv
// Shared NoC constants for the leaf switch: flit geometry, header field
// positions and input/output port numbering.
package noc_pkg;

    localparam int DATA_W     = 16;
    localparam int HEADER_W   = 6;

    // Header occupies the top HEADER_W bits of a flit: {group, leaf}
    localparam int GROUP_W    = 4;
    localparam int LEAF_W     = 2;
    localparam int GROUP_MSB  = 15;
    localparam int GROUP_LSB  = 12;
    localparam int LEAF_MSB   = 11;
    localparam int LEAF_LSB   = 10;

    localparam int NUM_LOCAL  = 4;
    localparam int UPLINK_IDX = 4;
    localparam int NUM_PORTS  = NUM_LOCAL + 1;

    typedef logic [2:0] port_idx_t;

endpackage

// File: rtl/switch_fifo.sv
// Circular flit buffer used at every switch input; the head entry is visible
// combinationally so a flit can leave the cycle after it is written.
module switch_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             data_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush;
    logic             doPop;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Writes into a full buffer and reads from an empty one are ignored
    assign doPush = push_i && (count_q != CNT_W'(DEPTH));
    assign doPop  = pop_i && (count_q != '0);

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) wrPtr_d = nextPtr(wrPtr_q);
        if (doPop)  rdPtr_d = nextPtr(rdPtr_q);
        if (doPush && !doPop) count_d = count_q + CNT_W'(1);
        if (!doPush && doPop) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q] <= data_i;
    end

    assign data_o  = mem_q[rdPtr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/leaf_switch.sv
// Five-port leaf switch: four local network interfaces plus one uplink, each
// input buffered, each output registered and round-robin arbitrated.
module leaf_switch #(
    parameter int DATA_W     = noc_pkg::DATA_W,
    parameter int HEADER_W   = noc_pkg::HEADER_W,
    parameter int GROUP_ID   = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4*DATA_W-1:0] loc_data_in,
    input  logic [3:0]          loc_valid_in,
    output logic [3:0]          loc_ready_out,
    output logic [4*DATA_W-1:0] loc_data_out,
    output logic [3:0]          loc_valid_out,
    input  logic [3:0]          loc_ready_in,
    input  logic [DATA_W-1:0]   up_data_in,
    input  logic                up_valid_in,
    output logic                up_ready_out,
    output logic [DATA_W-1:0]   up_data_out,
    output logic                up_valid_out,
    input  logic                up_ready_in,
    output logic [7:0]          drop_count
);

    import noc_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0]    inData     [NUM_PORTS];
    logic [DATA_W-1:0]    headData   [NUM_PORTS];
    logic [CNT_W-1:0]     fifoCount  [NUM_PORTS];
    port_idx_t            headDest   [NUM_PORTS];
    logic [NUM_PORTS-1:0] inValid;
    logic [NUM_PORTS-1:0] inReady;
    logic [NUM_PORTS-1:0] outReady;
    logic [NUM_PORTS-1:0] fifoPush;
    logic [NUM_PORTS-1:0] fifoPop;
    logic [NUM_PORTS-1:0] fifoEmpty;
    logic [NUM_PORTS-1:0] headDrop;

    logic [NUM_PORTS-1:0] outValid_q, outValid_d;
    logic [DATA_W-1:0]    outData_q  [NUM_PORTS];
    logic [DATA_W-1:0]    outData_d  [NUM_PORTS];
    port_idx_t            rrPtr_q    [NUM_PORTS];
    port_idx_t            rrPtr_d    [NUM_PORTS];
    logic [7:0]           dropCount_q, dropCount_d;

    always_comb begin
        for (int i = 0; i < NUM_LOCAL; i++) begin
            inData[i]   = loc_data_in[i*DATA_W +: DATA_W];
            inValid[i]  = loc_valid_in[i];
            outReady[i] = loc_ready_in[i];
        end
        inData[UPLINK_IDX]   = up_data_in;
        inValid[UPLINK_IDX]  = up_valid_in;
        outReady[UPLINK_IDX] = up_ready_in;
    end

    // Ready comes only from the registered fill level, so a full buffer never
    // accepts a flit even if its head leaves in the same cycle
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            inReady[i] = !reset && (fifoCount[i] != CNT_W'(FIFO_DEPTH));
        end
    end

    assign fifoPush      = inValid & inReady;
    assign loc_ready_out = inReady[NUM_LOCAL-1:0];
    assign up_ready_out  = inReady[UPLINK_IDX];

    for (genvar g = 0; g < NUM_PORTS; g++) begin : gFifo
        switch_fifo #(
            .WIDTH (DATA_W),
            .DEPTH (FIFO_DEPTH)
        ) uFifo (
            .clk     (clk),
            .reset   (reset),
            .push_i  (fifoPush[g]),
            .data_i  (inData[g]),
            .pop_i   (fifoPop[g]),
            .data_o  (headData[g]),
            .empty_o (fifoEmpty[g]),
            .count_o (fifoCount[g])
        );
    end

    // Foreign-group flits from the uplink have nowhere to go and are discarded
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            logic localHit;
            localHit    = (headData[i][DATA_W-1 -: GROUP_W] == GROUP_W'(GROUP_ID));
            headDest[i] = localHit ? port_idx_t'(headData[i][DATA_W-HEADER_W +: LEAF_W])
                                   : port_idx_t'(UPLINK_IDX);
            headDrop[i] = (i == UPLINK_IDX) && !fifoEmpty[i] && !localHit;
        end
    end

    // rrPtr holds the first input to consider, i.e. one past the last winner
    always_comb begin
        logic       found;
        logic [3:0] sum;
        port_idx_t  cand;
        found      = 1'b0;
        sum        = '0;
        cand       = '0;
        fifoPop    = headDrop;
        outValid_d = outValid_q;
        outData_d  = outData_q;
        rrPtr_d    = rrPtr_q;
        for (int o = 0; o < NUM_PORTS; o++) begin
            found = 1'b0;
            if (outValid_q[o] && outReady[o]) outValid_d[o] = 1'b0;
            if (!outValid_q[o] || outReady[o]) begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    sum = {1'b0, rrPtr_q[o]} + 4'(k);
                    if (sum >= 4'(NUM_PORTS)) sum = sum - 4'(NUM_PORTS);
                    cand = sum[2:0];
                    if (!found && !fifoEmpty[cand] && !headDrop[cand] &&
                        (headDest[cand] == port_idx_t'(o))) begin
                        found         = 1'b1;
                        fifoPop[cand] = 1'b1;
                        outValid_d[o] = 1'b1;
                        outData_d[o]  = headData[cand];
                        rrPtr_d[o]    = (cand == port_idx_t'(NUM_PORTS - 1)) ? '0
                                                                             : cand + 3'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        dropCount_d = dropCount_q;
        if (headDrop[UPLINK_IDX] && (dropCount_q != 8'hFF)) dropCount_d = dropCount_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outValid_q  <= '0;
            dropCount_q <= '0;
            for (int o = 0; o < NUM_PORTS; o++) begin
                outData_q[o] <= '0;
                rrPtr_q[o]   <= '0;
            end
        end else begin
            outValid_q  <= outValid_d;
            dropCount_q <= dropCount_d;
            for (int o = 0; o < NUM_PORTS; o++) begin
                outData_q[o] <= outData_d[o];
                rrPtr_q[o]   <= rrPtr_d[o];
            end
        end
    end

    always_comb begin
        for (int o = 0; o < NUM_LOCAL; o++) begin
            loc_data_out[o*DATA_W +: DATA_W] = outData_q[o];
        end
    end

    assign loc_valid_out = outValid_q[NUM_LOCAL-1:0];
    assign up_data_out   = outData_q[UPLINK_IDX];
    assign up_valid_out  = outValid_q[UPLINK_IDX];
    assign drop_count    = dropCount_q;

endmodule

// File: doc/leaf_switch.md
LEAF_SWITCH -- requirements
Module: leaf_switch

Interface
REQ-001 Parameters: DATA_W, default 16, flit width; HEADER_W, default 6, header width at flit bits [15:10] ({group[3:0], leaf[1:0]}); GROUP_ID, default 8, this switch's 4-bit group; FIFO_DEPTH, default 2, per-input buffer depth.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  clock.
REQ-004 reset  in  1  asynchronous active-high reset.
REQ-005 loc_data_in  in  4*DATA_W  flits from 4 network interfaces; port i occupies [16i+15:16i].
REQ-006 loc_valid_in  in  4  per-port flit valid.
REQ-007 loc_ready_out  out  4  per-port input FIFO not full.
REQ-008 loc_data_out  out  4*DATA_W  flits to network interfaces, same packing.
REQ-009 loc_valid_out  out  4  per-port output valid.
REQ-010 loc_ready_in  in  4  per-port sink ready; tied high for sinks without backpressure.
REQ-011 up_data_in / up_valid_in / up_ready_out  in/in/out  DATA_W/1/1  uplink ingress from parent router.
REQ-012 up_data_out / up_valid_out / up_ready_in  out/out/in  DATA_W/1/1  uplink egress to parent router.
REQ-013 drop_count  out  8  count of misrouted uplink flits dropped.

Function
REQ-014 Transfer on any port occurs on a rising edge where valid and ready are both high.
REQ-015 Input ports numbered 0-3 local, 4 uplink; each has its own FIFO_DEPTH-entry FIFO; ready_out equals not-full from registered count.
REQ-016 Simultaneous push and pop on a full FIFO is not allowed: ready_out depends only on registered count.
REQ-017 Routing of local-input head flit: header group == GROUP_ID -> local output header[11:10] (hairpin to own port allowed); otherwise -> uplink output.
REQ-018 Routing of uplink-input head flit: group == GROUP_ID -> local output header[11:10]; otherwise popped without forwarding, drop_count incremented, saturating at 255.
REQ-019 Flits are forwarded unmodified; no header rewrite.
REQ-020 Each of the 5 outputs has one output register; it loads when empty or when its current flit is consumed that cycle.
REQ-021 Per-output round-robin arbiter over the 5 inputs; the first requester at or after (last grant + 1) mod 5 wins; pointer updates only on grant.
REQ-022 At most one flit granted per output per cycle and each input granted at most one output per cycle; loser holds its head flit.
REQ-023 Latency: flit accepted at edge N appears on output valid after edge N+1 (2-cycle cut-through minimum, uncontended, output empty).
REQ-024 Output valid and data held stable until consumed; no retraction.
REQ-025 Per-output order from a single input is preserved.

Reset
REQ-026 During reset: all FIFO counts and pointers 0, all ready_out low until reset deasserts, all valid_out 0, data_out 0, arbiter pointers 0, drop_count 0.
REQ-027 Reset asserted mid-operation discards all buffered and in-flight flits; first cycle after deassertion all ready_out high.

Structure
REQ-028 Shared package noc_pkg: DATA_W, HEADER_W, group/leaf bit positions, NUM_LOCAL=4, UPLINK_IDX=4.
REQ-029 One sub-module switch_fifo (parameterised width/depth, push/pop, full/empty, count), instantiated 5 times; arbiter and crossbar inline.

Verification (GROUP_ID=8)
REQ-030 Port 0 sends 0x8455 (group 8, leaf 1) -> loc_data_out[31:16]=0x8455, loc_valid_out[1]=1 two edges later, one cycle only.
REQ-031 Port 2 sends 0x2C01 (group 2) -> up_data_out=0x2C01 two edges later; uplink sends 0x2C01 -> no output, drop_count=1.
REQ-032 Ports 0 and 2 send 0x8C11 and 0x8C22 same cycle to port 3 -> 0x8C11 then 0x8C22 on consecutive cycles; repeat -> 0x8C22's port granted first.
REQ-033 up_ready_in=0, port 1 streams 0x2C01..0x2C04 -> 3 accepted (1 in output register, 2 in FIFO), loc_ready_out[1]=0; raise up_ready_in -> 0x2C01..0x2C04 in order, none lost.
REQ-034 Reset asserted with 2 flits buffered on port 0 -> after deassertion all valid_out=0, drop_count=0, no stale flit emitted.
